// File: rtl/vga_sram_responder.sv
// SRAM responder shared by the VGA fetch port and the CPU bus: VGA-priority
// arbitration with a burst limit, fixed-latency access, one-cycle completion pulse.
module vga_sram_responder #(
   parameter int unsigned ADDR_W       = 9,
   parameter int unsigned SRAM_LATENCY = 2,
   parameter int unsigned VGA_BURST    = 8
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              vga_read,
   input  logic [31:0]       vga_address,
   input  logic [3:0]        vga_byte_select_req,
   output logic              vga_data_en,
   output logic [3:0]        vga_byte_select,
   output logic [31:0]       vga_data,
   input  logic              cpu_read,
   input  logic              cpu_write,
   input  logic [31:0]       cpu_address,
   input  logic [31:0]       cpu_wdata,
   input  logic [3:0]        cpu_byte_select,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_busy,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_wdata,
   output logic [3:0]        sram_byte_en,
   output logic              sram_ren,
   output logic              sram_wen,
   input  logic [31:0]       sram_rdata
);

   localparam int unsigned   BW        = $clog2(VGA_BURST + 1);
   localparam logic [BW-1:0] BURST_MAX = BW'(VGA_BURST);
   localparam logic [2:0]    LAT_LAST  = 3'(SRAM_LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

   state_t        state_q, state_d;
   logic [BW-1:0] burst_q, burst_d;
   logic [2:0]    lat_q, lat_d;
   logic [31:0]   addr_q, addr_d;
   logic [3:0]    lanes_q, lanes_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          req_vga_q, req_vga_d;
   logic          req_wr_q, req_wr_d;
   logic [31:0]   vga_data_q, vga_data_d;
   logic [3:0]    vga_bsel_q, vga_bsel_d;
   logic [31:0]   cpu_rdata_q, cpu_rdata_d;

   logic        cpu_req;
   logic        oor;
   logic        capture;
   logic [31:0] rd_word;

   assign cpu_req = cpu_read | cpu_write;
   assign oor     = |addr_q[31:ADDR_W];
   assign rd_word = oor ? '0 : sram_rdata;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= S_IDLE;
         burst_q     <= '0;
         lat_q       <= '0;
         addr_q      <= '0;
         lanes_q     <= '0;
         wdata_q     <= '0;
         req_vga_q   <= 1'b0;
         req_wr_q    <= 1'b0;
         vga_data_q  <= '0;
         vga_bsel_q  <= '0;
         cpu_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         burst_q     <= burst_d;
         lat_q       <= lat_d;
         addr_q      <= addr_d;
         lanes_q     <= lanes_d;
         wdata_q     <= wdata_d;
         req_vga_q   <= req_vga_d;
         req_wr_q    <= req_wr_d;
         vga_data_q  <= vga_data_d;
         vga_bsel_q  <= vga_bsel_d;
         cpu_rdata_q <= cpu_rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      burst_d      = burst_q;
      lat_d        = lat_q;
      addr_d       = addr_q;
      lanes_d      = lanes_q;
      wdata_d      = wdata_q;
      req_vga_d    = req_vga_q;
      req_wr_d     = req_wr_q;
      vga_data_d   = vga_data_q;
      vga_bsel_d   = vga_bsel_q;
      cpu_rdata_d  = cpu_rdata_q;
      sram_byte_en = '0;
      sram_ren     = 1'b0;
      sram_wen     = 1'b0;
      capture      = 1'b0;

      case (state_q)
         S_IDLE: begin
            // A pending CPU request implies burst_q < BURST_MAX here, so no extra saturation test.
            if (vga_read && (!cpu_req || burst_q < BURST_MAX)) begin
               addr_d    = vga_address;
               lanes_d   = vga_byte_select_req;
               req_vga_d = 1'b1;
               req_wr_d  = 1'b0;
               burst_d   = cpu_req ? burst_q + 1'b1 : '0;
               state_d   = S_ACCESS;
            end else if (cpu_req) begin
               addr_d    = cpu_address;
               lanes_d   = cpu_byte_select;
               wdata_d   = cpu_wdata;
               req_vga_d = 1'b0;
               req_wr_d  = ~cpu_read;
               burst_d   = '0;
               state_d   = S_ACCESS;
            end else begin
               burst_d   = '0;
            end
         end
         S_ACCESS: begin
            sram_byte_en = lanes_q;
            if (req_wr_q) begin
               sram_wen = ~oor & (|lanes_q);
               state_d  = S_RESP;
            end else begin
               sram_ren = ~oor;
               if (SRAM_LATENCY == 1) begin
                  capture = 1'b1;
                  state_d = S_RESP;
               end else begin
                  lat_d   = 3'd1;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (lat_q == LAT_LAST) begin
               capture = 1'b1;
               lat_d   = '0;
               state_d = S_RESP;
            end else begin
               lat_d   = lat_q + 3'd1;
            end
         end
         S_RESP: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (capture) begin
         if (req_vga_q) begin
            vga_data_d = rd_word;
            vga_bsel_d = lanes_q;
         end else begin
            cpu_rdata_d = rd_word;
         end
      end
   end

   assign sram_addr       = addr_q[ADDR_W-1:0];
   assign sram_wdata      = wdata_q;
   assign vga_data        = vga_data_q;
   assign vga_byte_select = vga_bsel_q;
   assign cpu_rdata       = cpu_rdata_q;
   assign vga_data_en     = (state_q == S_RESP) &  req_vga_q;
   assign cpu_ack         = (state_q == S_RESP) & ~req_vga_q;
   // Gated by nrst so every output reads 0 while reset is held, even with vga_read high.
   assign cpu_busy        = nrst & ((state_q != S_IDLE) | (vga_read & (burst_q < BURST_MAX)));

endmodule

// File: tb/tb_vga_sram_responder.sv
// Directed bench for vga_sram_responder with a one-stage registered SRAM model
// (default SRAM_LATENCY of 2); each task checks its own scenario.
module tb_vga_sram_responder;

   logic        clk = 1'b0;
   logic        nrst;
   logic        vga_read;
   logic [31:0] vga_address;
   logic [3:0]  vga_byte_select_req;
   logic        vga_data_en;
   logic [3:0]  vga_byte_select;
   logic [31:0] vga_data;
   logic        cpu_read;
   logic        cpu_write;
   logic [31:0] cpu_address;
   logic [31:0] cpu_wdata;
   logic [3:0]  cpu_byte_select;
   logic [31:0] cpu_rdata;
   logic        cpu_ack;
   logic        cpu_busy;
   logic [8:0]  sram_addr;
   logic [31:0] sram_wdata;
   logic [3:0]  sram_byte_en;
   logic        sram_ren;
   logic        sram_wen;
   logic [31:0] sram_rdata;

   int checks = 0;
   int errors = 0;
   int ren_cnt = 0;
   int wen_cnt = 0;
   int both_cnt = 0;
   int dv_cnt = 0;

   logic [31:0] mem [0:511];
   logic [31:0] rdata_pipe;

   always #5 clk = ~clk;

   vga_sram_responder #(.ADDR_W(9), .SRAM_LATENCY(2), .VGA_BURST(8)) dut (
      .clk(clk), .nrst(nrst),
      .vga_read(vga_read), .vga_address(vga_address),
      .vga_byte_select_req(vga_byte_select_req), .vga_data_en(vga_data_en),
      .vga_byte_select(vga_byte_select), .vga_data(vga_data),
      .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
      .cpu_wdata(cpu_wdata), .cpu_byte_select(cpu_byte_select),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_busy(cpu_busy),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_byte_en(sram_byte_en),
      .sram_ren(sram_ren), .sram_wen(sram_wen), .sram_rdata(sram_rdata)
   );

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   // SRAM model: read data valid the cycle after sram_ren; contents reload on reset.
   always @(posedge clk) begin
      if (!nrst) begin
         for (int i = 0; i < 512; i++)
            mem[i] <= (i == 5) ? 32'h6AAA5556 : (32'hC0DE0000 | 32'(i));
         rdata_pipe <= '0;
      end else begin
         if (sram_ren) rdata_pipe <= mem[sram_addr];
         if (sram_wen) mem[sram_addr] <= merge(mem[sram_addr], sram_wdata, sram_byte_en);
      end
   end
   assign sram_rdata = rdata_pipe;

   always @(negedge clk) begin
      if (sram_ren) ren_cnt++;
      if (sram_wen) wen_cnt++;
      if (sram_ren && sram_wen) both_cnt++;
      if (vga_data_en) dv_cnt++;
   end

   // Observes one transaction; cycle 0 is the first negedge after the request is driven.
   task automatic run_txn(input int budget, output int t_ren, output int t_wen, output int t_done,
                          output logic [8:0] a_ren, output logic [3:0] be_wen);
      t_ren = -1; t_wen = -1; t_done = -1; a_ren = '0; be_wen = '0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (sram_ren && t_ren < 0) begin t_ren = c; a_ren = sram_addr; end
         if (sram_wen && t_wen < 0) begin t_wen = c; be_wen = sram_byte_en; end
         if (vga_data_en || cpu_ack) begin
            t_done = c;
            vga_read = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
            break;
         end
      end
      vga_read = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
   endtask

   task automatic test_reset;
      nrst = 1'b0;
      vga_read = 0; vga_address = '0; vga_byte_select_req = '0;
      cpu_read = 0; cpu_write = 0; cpu_address = '0; cpu_wdata = '0; cpu_byte_select = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({vga_data_en, vga_byte_select, vga_data, cpu_rdata, cpu_ack, cpu_busy, sram_addr,
           sram_wdata, sram_byte_en, sram_ren, sram_wen} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got vga_data=%h cpu_busy=%b sram_addr=%h, want all 0",
                  vga_data, cpu_busy, sram_addr);
      end
      @(posedge clk); #1 nrst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_vga_read;
      int tr, tw, td; logic [8:0] a; logic [3:0] be; int r0;
      r0 = ren_cnt;
      @(posedge clk); #1;
      vga_read = 1; vga_address = 32'd5; vga_byte_select_req = 4'hF;
      run_txn(20, tr, tw, td, a, be);
      checks++; if (tr !== 1) begin errors++; $display("FAIL vga_ren_cycle: got %0d want 1", tr); end
      checks++; if (a !== 9'd5) begin errors++; $display("FAIL vga_ren_addr: got %0d want 5", a); end
      checks++; if (ren_cnt - r0 !== 1) begin errors++; $display("FAIL vga_ren_count: got %0d want 1", ren_cnt - r0); end
      checks++; if (td !== 3) begin errors++; $display("FAIL vga_data_en_cycle: got %0d want 3", td); end
      checks++; if (vga_data !== 32'h6AAA5556) begin errors++; $display("FAIL vga_data: got %h want 6aaa5556", vga_data); end
      checks++; if (vga_byte_select !== 4'hF) begin errors++; $display("FAIL vga_bsel: got %h want f", vga_byte_select); end
   endtask

   task automatic test_cpu_write_read;
      int tr, tw, td; logic [8:0] a; logic [3:0] be; int w0, r0;
      w0 = wen_cnt; r0 = ren_cnt;
      @(posedge clk); #1;
      cpu_write = 1; cpu_address = 32'd10; cpu_wdata = 32'hDEADBEEF; cpu_byte_select = 4'b0011;
      run_txn(20, tr, tw, td, a, be);
      checks++; if (tw !== 1) begin errors++; $display("FAIL wr_wen_cycle: got %0d want 1", tw); end
      checks++; if (be !== 4'b0011) begin errors++; $display("FAIL wr_byte_en: got %b want 0011", be); end
      checks++; if (td !== 2) begin errors++; $display("FAIL wr_ack_cycle: got %0d want 2", td); end
      checks++; if (wen_cnt - w0 !== 1 || ren_cnt !== r0) begin
         errors++; $display("FAIL wr_strobes: got wen=%0d ren=%0d want 1 0", wen_cnt - w0, ren_cnt - r0); end
      @(posedge clk); #1;
      cpu_read = 1; cpu_address = 32'd10; cpu_byte_select = 4'hF;
      run_txn(20, tr, tw, td, a, be);
      checks++; if (td !== 3) begin errors++; $display("FAIL rd_ack_cycle: got %0d want 3", td); end
      checks++; if (cpu_rdata !== 32'hC0DEBEEF) begin errors++; $display("FAIL rd_data: got %h want c0debeef", cpu_rdata); end
      checks++; if (vga_data !== 32'h6AAA5556) begin errors++; $display("FAIL vga_data_hold: got %h want 6aaa5556", vga_data); end
   endtask

   task automatic test_out_of_range;
      int tr, tw, td; logic [8:0] a; logic [3:0] be; int r0;
      r0 = ren_cnt;
      @(posedge clk); #1;
      vga_read = 1; vga_address = 32'h200; vga_byte_select_req = 4'h3;
      run_txn(20, tr, tw, td, a, be);
      checks++; if (ren_cnt !== r0) begin errors++; $display("FAIL oor_no_ren: got %0d strobes want 0", ren_cnt - r0); end
      checks++; if (td !== 3) begin errors++; $display("FAIL oor_cycle: got %0d want 3", td); end
      checks++; if (vga_data !== 32'h0) begin errors++; $display("FAIL oor_data: got %h want 0", vga_data); end
      checks++; if (vga_byte_select !== 4'h3) begin errors++; $display("FAIL oor_bsel: got %h want 3", vga_byte_select); end
   endtask

   task automatic test_zero_lane_write;
      int tr, tw, td; logic [8:0] a; logic [3:0] be; int w0;
      w0 = wen_cnt;
      @(posedge clk); #1;
      cpu_write = 1; cpu_address = 32'd10; cpu_wdata = 32'hFFFFFFFF; cpu_byte_select = 4'b0000;
      run_txn(20, tr, tw, td, a, be);
      checks++; if (wen_cnt !== w0) begin errors++; $display("FAIL zl_no_wen: got %0d strobes want 0", wen_cnt - w0); end
      checks++; if (td !== 2) begin errors++; $display("FAIL zl_ack_cycle: got %0d want 2", td); end
      checks++; if (mem[10] !== 32'hC0DEBEEF) begin errors++; $display("FAIL zl_mem: got %h want c0debeef", mem[10]); end
   endtask

   task automatic test_starvation;
      int vga_done, vga_at_ack, t_ack, acks, first_free, t_resume;
      vga_done = 0; vga_at_ack = -1; t_ack = -1; acks = 0; first_free = -1; t_resume = -1;
      @(posedge clk); #1;
      vga_read = 1; vga_address = 32'd7; vga_byte_select_req = 4'hF;
      cpu_read = 1; cpu_address = 32'd5; cpu_byte_select = 4'hF;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (!cpu_busy && first_free < 0) first_free = c;
         if (cpu_ack) begin
            acks++; t_ack = c; vga_at_ack = vga_done; cpu_read = 1'b0;
         end
         if (vga_data_en) begin
            vga_done++;
            if (t_ack >= 0) begin t_resume = c; vga_read = 1'b0; break; end
         end
      end
      vga_read = 1'b0; cpu_read = 1'b0;
      checks++; if (vga_at_ack !== 8) begin errors++; $display("FAIL starve_vga_count: got %0d want 8", vga_at_ack); end
      checks++; if (first_free !== 32) begin errors++; $display("FAIL starve_busy: first free cycle %0d want 32", first_free); end
      checks++; if (t_ack !== 35 || acks !== 1) begin errors++; $display("FAIL starve_ack: got cycle %0d count %0d want 35 1", t_ack, acks); end
      checks++; if (cpu_rdata !== 32'h6AAA5556) begin errors++; $display("FAIL starve_rdata: got %h want 6aaa5556", cpu_rdata); end
      checks++; if (t_resume !== 39) begin errors++; $display("FAIL starve_resume: got %0d want 39", t_resume); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_abort;
      int d0;
      @(posedge clk); #1;
      vga_read = 1; vga_address = 32'd10; vga_byte_select_req = 4'hF;
      @(posedge clk); @(posedge clk); #2;
      nrst = 1'b0;
      #1;
      checks++;
      if ({vga_data_en, vga_byte_select, vga_data, cpu_rdata, cpu_ack, cpu_busy, sram_addr,
           sram_wdata, sram_byte_en, sram_ren, sram_wen} !== '0) begin
         errors++;
         $display("FAIL abort_outputs: got vga_data=%h cpu_rdata=%h cpu_busy=%b sram_addr=%h, want all 0",
                  vga_data, cpu_rdata, cpu_busy, sram_addr);
      end
      d0 = dv_cnt;
      vga_read = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk); #1 nrst = 1'b1;
      repeat (8) @(negedge clk);
      checks++; if (dv_cnt !== d0) begin errors++; $display("FAIL abort_no_pulse: got %0d pulses want 0", dv_cnt - d0); end
   endtask

   initial begin
      test_reset;
      test_vga_read;
      test_cpu_write_read;
      test_out_of_range;
      test_zero_lane_write;
      test_starvation;
      test_reset_abort;
      checks++;
      if (both_cnt !== 0) begin errors++; $display("FAIL strobe_exclusive: got %0d cycles with both strobes want 0", both_cnt); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
